// File: rtl/light_pkg.sv
// Shared types and constants for the traffic light controller and its phase timer.
package light_pkg;

  localparam int unsigned DUR_W            = 5;
  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } timer_state_t;

  // Packs {tens, ones} BCD digits of a phase duration (0..31).
  function automatic logic [7:0] to_bcd(input logic [DUR_W-1:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / DUR_W'(10));
    ones = 4'(v % DUR_W'(10));
    return {tens, ones};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler dividing clk into a single-cycle tick every TICK_DIV cycles.
module tick_gen
  import light_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/light_timer.sv
// Per-phase countdown timer feeding the light-sequencing FSM.
// Optional BCD display outputs are enabled with LIGHT_TIMER_BCD_EN.
module light_timer
  import light_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DUR_W-1:0] count,
  output logic             finish,
  output logic             pre_last,
  output logic [DUR_W-1:0] remaining
`ifdef LIGHT_TIMER_BCD_EN
  ,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones
`endif
);

  timer_state_t     state;
  timer_state_t     state_nxt;
  logic [DUR_W-1:0] remaining_nxt;
  logic             tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(state != RUN),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      LOAD: begin
        remaining_nxt = (count == '0) ? DUR_W'(1) : count;
        state_nxt     = RUN;
      end
      RUN: begin
        // The last second holds at 1 through DONE so pre_last stays up with finish.
        if (tick) begin
          if (remaining > DUR_W'(1)) begin
            remaining_nxt = remaining - DUR_W'(1);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        remaining_nxt = '0;
        state_nxt     = LOAD;
      end
      default: begin
        remaining_nxt = '0;
        state_nxt     = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
    end else begin
      remaining <= remaining_nxt;
    end
  end

  assign finish   = (state == DONE);
  assign pre_last = (remaining == DUR_W'(1));

`ifdef LIGHT_TIMER_BCD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      {sec_tens, sec_ones} <= '0;
    end else begin
      {sec_tens, sec_ones} <= to_bcd(remaining_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_light_timer.sv
// Self-checking bench for light_timer with TICK_DIV = 4; BCD checks when LIGHT_TIMER_BCD_EN is defined.
module tb_light_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] count = 5'd3;
  logic       finish;
  logic       pre_last;
  logic [4:0] remaining;
`ifdef LIGHT_TIMER_BCD_EN
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  light_timer #(
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .finish   (finish),
    .pre_last (pre_last),
    .remaining(remaining)
`ifdef LIGHT_TIMER_BCD_EN
    ,
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Phase model: m_t is cycles since LOAD entry (0 = in LOAD), m_d the loaded duration.
  int m_t     = 0;
  int m_d     = 1;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_t     = 0;
      m_valid = 1'b1;
    end else if (m_t == 0) begin
      m_d = (count == 5'd0) ? 1 : int'(count);
      m_t = 1;
    end else if (m_t == TD * m_d + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    int k, er, ep, ef;
    if (m_valid) begin
      if (m_t == 0) begin
        er = 0; ep = 0; ef = 0;
      end else begin
        k  = (m_t - 1) / TD;
        er = (m_d > k) ? (m_d - k) : 1;
        ep = (k >= m_d - 1) ? 1 : 0;
        ef = (m_t == TD * m_d + 1) ? 1 : 0;
      end
      check("model_remaining", int'(remaining), er);
      check("model_pre_last", int'(pre_last), ep);
      check("model_finish", int'(finish), ef);
`ifdef LIGHT_TIMER_BCD_EN
      check("model_sec_tens", int'(sec_tens), er / 10);
      check("model_sec_ones", int'(sec_ones), er % 10);
`endif
    end
  end

  task automatic wait_finish(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (finish) begin
        at = cyc;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_finish: got timeout after %0d cycles, expected finish pulse", bound);
  endtask

  // Enters at a DONE negedge; walks one short phase and checks pre_last length and finish position.
  task automatic short_phase(input string name);
    int n;
    int fpos;
    n    = 0;
    fpos = 0;
    @(negedge clk);
    check({name, "_load_pre_last"}, int'(pre_last), 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pre_last) n++;
      if (finish) begin
        fpos = i;
        break;
      end
    end
    check({name, "_pre_last_len"}, n, 5);
    check({name, "_finish_pos"}, fpos, 5);
  endtask

  initial begin
    int c0, c1, c2;
    repeat (3) @(negedge clk);
    check("reset_finish", int'(finish), 0);
    check("reset_pre_last", int'(pre_last), 0);
    check("reset_remaining", int'(remaining), 0);
    rst = 1'b0;

    @(negedge clk);
    check("load_d3", int'(remaining), 3);
    wait_finish(60, c1);
    wait_finish(60, c2);
    check("phase_len_d3", c2 - c1, 14);

    count = 5'd1;
    short_phase("d1");
    count = 5'd0;
    short_phase("d0");

    count = 5'd5;
    @(negedge clk);
    c0 = cyc;
    repeat (6) @(negedge clk);
    count = 5'd9;
    wait_finish(60, c1);
    check("d5_len_ignores_count", c1 - c0, 21);
    @(negedge clk);
    @(negedge clk);
    check("reload_d9", int'(remaining), 9);

    repeat (35) @(negedge clk);
    check("pre_abort_finish", int'(finish), 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_finish", int'(finish), 0);
    check("abort_remaining", int'(remaining), 0);
    check("abort_pre_last", int'(pre_last), 0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_d9", int'(remaining), 9);

    wait_finish(60, c1);
    count = 5'd18;
    @(negedge clk);
    @(negedge clk);
    check("load_d18", int'(remaining), 18);
`ifdef LIGHT_TIMER_BCD_EN
    check("bcd18_tens", int'(sec_tens), 1);
    check("bcd18_ones", int'(sec_ones), 8);
`endif
    repeat (TD * 9) @(negedge clk);
    check("d18_after9", int'(remaining), 9);
`ifdef LIGHT_TIMER_BCD_EN
    check("bcd9_tens", int'(sec_tens), 0);
    check("bcd9_ones", int'(sec_ones), 9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
